mini_fir_ctrl: RTL and testbench
================================

MINI_FIR_CTRL -- requirements
Module: mini_fir_ctrl

Interface
REQ-001 The block SHALL have parameter DRAIN_CYC, default 8: number of zero-input cycles used to flush the datapath (6 tap registers + 2 latency).
REQ-002 The block SHALL have parameter LAT, default 2: datapath latency in cycles from o_fir_din to i_fir_dout.
REQ-003 The block SHALL have port clk, input, 1: single clock, all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_din_vld, input, 1: input sample valid.
REQ-006 The block SHALL have port i_din, input, 8: input sample.
REQ-007 The block SHALL have port o_din_rdy, output, 1: sample accepted when i_din_vld and o_din_rdy are both high.
REQ-008 The block SHALL have port i_cfg_vld, input, 1: coefficient write strobe.
REQ-009 The block SHALL have port i_cfg_addr, input, 3: tap index 0..6; values 7 are ignored.
REQ-010 The block SHALL have port i_cfg_data, input, 8: coefficient value.
REQ-011 The block SHALL have port o_cfg_rdy, output, 1: a write is taken when i_cfg_vld and o_cfg_rdy are both high.
REQ-012 The block SHALL have port i_commit, input, 1: single-cycle request to apply the shadow coefficients.
REQ-013 The block SHALL have ports o_coeff_00..o_coeff_06, output, 8 each: active coefficients to the datapath.
REQ-014 The block SHALL have port o_fir_din, output, 8: sample driven to the datapath every cycle.
REQ-015 The block SHALL have port i_fir_dout, input, 8: datapath output.
REQ-016 The block SHALL have port o_dout, output, 8: i_fir_dout passed through combinationally.
REQ-017 The block SHALL have port o_dout_vld, output, 1: o_dout corresponds to an accepted sample.
REQ-018 The block SHALL have port o_busy, output, 1: high in DRAIN or LOAD.

Function
REQ-019 The FSM SHALL have states RUN, DRAIN and LOAD; reset state is RUN.
REQ-020 In RUN, o_din_rdy SHALL be 1 and o_fir_din SHALL equal i_din when i_din_vld=1; otherwise o_fir_din SHALL be 0 (a gap is a zero sample).
REQ-021 A valid shift register of depth LAT SHALL carry the accept flag (i_din_vld & o_din_rdy), so that o_dout_vld = accept delayed by exactly LAT cycles.
REQ-022 Commit requests SHALL be latched in a pending flag; in RUN with the pending flag set, the FSM SHALL go to DRAIN on the next cycle and clear the flag.
REQ-023 In DRAIN, o_din_rdy SHALL be 0, o_fir_din SHALL be 0, and a counter SHALL run DRAIN_CYC cycles; on the last count the FSM SHALL go to LOAD.
REQ-024 The valid shift register SHALL keep shifting during DRAIN, so tail outputs of accepted samples still assert o_dout_vld; zero-fill cycles shift in 0.
REQ-025 LOAD SHALL last 1 cycle, copying all 7 shadow registers into the active registers at once, then return to RUN.
REQ-026 o_din_rdy SHALL be 0 in LOAD.
REQ-027 o_cfg_rdy SHALL be 1 in RUN and DRAIN and 0 in LOAD; accepted writes update only the shadow register selected by i_cfg_addr.
REQ-028 A cfg write and i_commit in the same cycle SHALL include that write in the committed set.
REQ-029 i_commit asserted during DRAIN or LOAD SHALL set the pending flag, producing exactly one further drain/load after returning to RUN; multiple requests coalesce into one.
REQ-030 Active coefficients SHALL change only in LOAD and SHALL never change while an accepted sample is inside the datapath.
REQ-031 o_busy SHALL be 1 exactly when the state is DRAIN or LOAD.

Reset
REQ-032 When rst=1 at a clock edge, all of the following SHALL apply:
- state becomes RUN;
- the pending flag, drain counter and valid shift register are cleared;
- shadow and active coefficients are set to 0;
- the following outputs are 0 on the next cycle: o_dout_vld, o_busy, o_coeff_*.
REQ-033 Reset asserted mid-DRAIN or mid-LOAD SHALL abort the sequence with no coefficient update.

Verification
REQ-034 Scenario (reset values): hold rst 2 cycles -> o_coeff_* = 0, o_busy = 0, o_dout_vld = 0, o_din_rdy = 1, o_cfg_rdy = 1.
REQ-035 Scenario (config and commit): write taps 0..6 = 1,2,4,8,16,32,64, then pulse i_commit -> o_busy high for 9 cycles (8 DRAIN + 1 LOAD), o_coeff_* update together on LOAD exit, and o_din_rdy is 0 throughout.
REQ-036 Scenario (latency): after the config scenario, send a single sample 0xFF then gaps -> o_dout_vld high exactly 2 cycles after accept, and only for that cycle.
REQ-037 Scenario (tail outputs): send a burst of 5 samples, with i_commit asserted on the 5th -> the last two accepted samples' o_dout_vld pulses appear during DRAIN, and no accepts occur until RUN resumes.
REQ-038 Scenario (coalesced commits): pulse i_commit 3 times during DRAIN -> exactly one extra DRAIN+LOAD sequence follows.
REQ-039 Scenario (reset mid-DRAIN): assert rst at drain count 4 -> state returns to RUN, coefficients read 0, and there is no LOAD cycle.

Source files
------------

// File: rtl/mini_fir_ctrl.sv
// Control wrapper for a 7-tap FIR datapath: streams samples, holds shadow/active coefficient
// banks and swaps them only after the datapath has been flushed with zeros.
module mini_fir_ctrl #(
    parameter int unsigned DRAIN_CYC = 8,
    parameter int unsigned LAT       = 2
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       i_din_vld,
    input  logic [7:0] i_din,
    output logic       o_din_rdy,

    input  logic       i_cfg_vld,
    input  logic [2:0] i_cfg_addr,
    input  logic [7:0] i_cfg_data,
    output logic       o_cfg_rdy,
    input  logic       i_commit,

    output logic [7:0] o_coeff_00,
    output logic [7:0] o_coeff_01,
    output logic [7:0] o_coeff_02,
    output logic [7:0] o_coeff_03,
    output logic [7:0] o_coeff_04,
    output logic [7:0] o_coeff_05,
    output logic [7:0] o_coeff_06,

    output logic [7:0] o_fir_din,
    input  logic [7:0] i_fir_dout,

    output logic [7:0] o_dout,
    output logic       o_dout_vld,
    output logic       o_busy
);

    localparam int unsigned NumTaps = 7;
    localparam int unsigned CntW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StLoad
    } state_e;

    state_e          state_q, state_d;
    logic            pending_q, pending_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [LAT-1:0]  vld_sr_q, vld_sr_d;
    logic [7:0]      shadow_q [NumTaps];
    logic [7:0]      shadow_d [NumTaps];
    logic [7:0]      active_q [NumTaps];
    logic [7:0]      active_d [NumTaps];

    logic accept;
    logic cfg_take;

    assign o_din_rdy = (state_q == StRun);
    assign o_cfg_rdy = (state_q != StLoad);
    assign o_busy    = (state_q != StRun);

    assign accept   = i_din_vld & o_din_rdy;
    assign cfg_take = i_cfg_vld & o_cfg_rdy & (i_cfg_addr != 3'd7);

    // Gaps and drain cycles feed zeros so the datapath history stays well defined.
    assign o_fir_din = accept ? i_din : 8'h00;

    assign o_dout     = i_fir_dout;
    assign o_dout_vld = vld_sr_q[LAT-1];

    generate
        if (LAT == 1) begin : g_vld_one
            assign vld_sr_d = accept;
        end else begin : g_vld_multi
            assign vld_sr_d = {vld_sr_q[LAT-2:0], accept};
        end
    endgenerate

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_take) begin
            shadow_d[i_cfg_addr] = i_cfg_data;
        end
    end

    // A commit seen in RUN (latched or same-cycle) starts the drain at the next edge.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | i_commit;
        cnt_d     = cnt_q;
        active_d  = active_q;
        unique case (state_q)
            StRun: begin
                if (pending_q | i_commit) begin
                    state_d   = StDrain;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            StDrain: begin
                if (cnt_q == CntLast) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLoad: begin
                active_d = shadow_q;
                state_d  = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            vld_sr_q  <= '0;
            for (int i = 0; i < NumTaps; i++) begin
                shadow_q[i] <= 8'h00;
                active_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            vld_sr_q  <= vld_sr_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign o_coeff_00 = active_q[0];
    assign o_coeff_01 = active_q[1];
    assign o_coeff_02 = active_q[2];
    assign o_coeff_03 = active_q[3];
    assign o_coeff_04 = active_q[4];
    assign o_coeff_05 = active_q[5];
    assign o_coeff_06 = active_q[6];

endmodule

// File: tb/tb_mini_fir_ctrl.sv
// Self-checking bench for mini_fir_ctrl: a two-stage delay line stands in for the datapath and
// a queue scoreboard tracks accepted samples until they reappear on o_dout.
module tb_mini_fir_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_din_vld;
    logic [7:0] i_din;
    logic       o_din_rdy;
    logic       i_cfg_vld;
    logic [2:0] i_cfg_addr;
    logic [7:0] i_cfg_data;
    logic       o_cfg_rdy;
    logic       i_commit;
    logic [7:0] o_coeff_00, o_coeff_01, o_coeff_02, o_coeff_03;
    logic [7:0] o_coeff_04, o_coeff_05, o_coeff_06;
    logic [7:0] o_fir_din;
    logic [7:0] i_fir_dout;
    logic [7:0] o_dout;
    logic       o_dout_vld;
    logic       o_busy;

    logic [7:0] coeff     [7];
    logic [7:0] exp_coeff [7];
    logic [7:0] dp1, dp2;
    logic [7:0] sb_q [$];

    int checks   = 0;
    int failures = 0;

    mini_fir_ctrl #(.DRAIN_CYC(8), .LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_din_vld  (i_din_vld),
        .i_din      (i_din),
        .o_din_rdy  (o_din_rdy),
        .i_cfg_vld  (i_cfg_vld),
        .i_cfg_addr (i_cfg_addr),
        .i_cfg_data (i_cfg_data),
        .o_cfg_rdy  (o_cfg_rdy),
        .i_commit   (i_commit),
        .o_coeff_00 (o_coeff_00),
        .o_coeff_01 (o_coeff_01),
        .o_coeff_02 (o_coeff_02),
        .o_coeff_03 (o_coeff_03),
        .o_coeff_04 (o_coeff_04),
        .o_coeff_05 (o_coeff_05),
        .o_coeff_06 (o_coeff_06),
        .o_fir_din  (o_fir_din),
        .i_fir_dout (i_fir_dout),
        .o_dout     (o_dout),
        .o_dout_vld (o_dout_vld),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: pure LAT=2 delay of the sample stream.
    always_ff @(posedge clk) begin
        dp1 <= o_fir_din;
        dp2 <= dp1;
    end
    assign i_fir_dout = dp2;

    always_comb begin
        coeff[0] = o_coeff_00;
        coeff[1] = o_coeff_01;
        coeff[2] = o_coeff_02;
        coeff[3] = o_coeff_03;
        coeff[4] = o_coeff_04;
        coeff[5] = o_coeff_05;
        coeff[6] = o_coeff_06;
    end

    // Called at the negedge: retire any output against the scoreboard, then move to the
    // next drive point just after the rising edge.
    task automatic advance();
        logic [7:0] sb_exp;
        if (o_dout_vld === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: o_dout_vld=1 o_dout=%h, required no output", o_dout);
            end else begin
                sb_exp = sb_q.pop_front();
                if (o_dout !== sb_exp) begin
                    failures++;
                    $display("FAIL sb_data: o_dout=%h, required %h", o_dout, sb_exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst        = 1'b0;
        i_din_vld  = 1'b0;
        i_din      = 8'h00;
        i_cfg_vld  = 1'b0;
        i_cfg_addr = 3'd0;
        i_cfg_data = 8'h00;
        i_commit   = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        i_din_vld  = 1'b1;
        i_din      = 8'hA5;
        i_cfg_vld  = 1'b1;
        i_cfg_addr = 3'd3;
        i_cfg_data = 8'hFF;
        i_commit   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            advance();
        end
        idle_inputs();
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            exp_coeff[i] = 8'h00;
            checks++;
            if (coeff[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_coeff%0d: got %h, required 00", i, coeff[i]);
            end
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b, required 0", o_busy);
        end
        checks++;
        if (o_dout_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_dout_vld: got %b, required 0", o_dout_vld);
        end
        checks++;
        if (o_din_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_din_rdy: got %b, required 1", o_din_rdy);
        end
        checks++;
        if (o_cfg_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_cfg_rdy: got %b, required 1", o_cfg_rdy);
        end
        advance();
    endtask

    task automatic test_config_commit();
        logic exp_busy;
        for (int i = 0; i < 8; i++) begin
            i_cfg_vld  = 1'b1;
            i_cfg_addr = 3'(i);
            i_cfg_data = (i == 7) ? 8'hAA : 8'(1 << i);
            @(negedge clk);
            checks++;
            if (o_cfg_rdy !== 1'b1) begin
                failures++;
                $display("FAIL cfg_rdy_run: got %b, required 1", o_cfg_rdy);
            end
            advance();
        end
        i_cfg_vld = 1'b0;
        i_commit  = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL commit_cycle_busy: got %b, required 0", o_busy);
        end
        advance();
        i_commit = 1'b0;
        for (int i = 0; i < 7; i++) exp_coeff[i] = 8'(1 << i);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_busy = (k < 9);
            checks++;
            if (o_busy !== exp_busy) begin
                failures++;
                $display("FAIL cfg_busy[%0d]: got %b, required %b", k, o_busy, exp_busy);
            end
            checks++;
            if (o_din_rdy !== !exp_busy) begin
                failures++;
                $display("FAIL cfg_din_rdy[%0d]: got %b, required %b", k, o_din_rdy, !exp_busy);
            end
            checks++;
            if (o_cfg_rdy !== (k != 8)) begin
                failures++;
                $display("FAIL cfg_rdy_load[%0d]: got %b, required %b", k, o_cfg_rdy, (k != 8));
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (coeff[i] !== ((k >= 9) ? exp_coeff[i] : 8'h00)) begin
                    failures++;
                    $display("FAIL cfg_coeff%0d[%0d]: got %h, required %h", i, k, coeff[i],
                             (k >= 9) ? exp_coeff[i] : 8'h00);
                end
            end
            advance();
        end
    endtask

    task automatic test_latency();
        i_din_vld = 1'b1;
        i_din     = 8'hFF;
        @(negedge clk);
        checks++;
        if (o_din_rdy !== 1'b1 || o_fir_din !== 8'hFF) begin
            failures++;
            $display("FAIL lat_accept: rdy=%b fir_din=%h, required 1 ff", o_din_rdy, o_fir_din);
        end
        sb_q.push_back(8'hFF);
        advance();
        i_din_vld = 1'b0;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (o_dout_vld !== (k == 2)) begin
                failures++;
                $display("FAIL lat_vld[%0d]: got %b, required %b", k, o_dout_vld, (k == 2));
            end
            checks++;
            if (o_fir_din !== 8'h00) begin
                failures++;
                $display("FAIL lat_gap_zero[%0d]: got %h, required 00", k, o_fir_din);
            end
            advance();
        end
    endtask

    task automatic test_tail();
        logic       exp_rdy, exp_busy, exp_dvld;
        logic [7:0] data;
        exp_coeff[0] = 8'h80;
        for (int k = 0; k < 18; k++) begin
            data       = (k < 5) ? 8'(8'h11 * (k + 1)) : 8'h99;
            i_din_vld  = (k <= 14);
            i_din      = data;
            i_commit   = (k == 4);
            i_cfg_vld  = (k == 4);
            i_cfg_addr = 3'd0;
            i_cfg_data = 8'h80;
            @(negedge clk);
            exp_rdy  = (k < 5) || (k >= 14);
            exp_busy = (k >= 5) && (k <= 13);
            exp_dvld = ((k >= 2) && (k <= 6)) || (k == 16);
            checks++;
            if (o_din_rdy !== exp_rdy) begin
                failures++;
                $display("FAIL tail_rdy[%0d]: got %b, required %b", k, o_din_rdy, exp_rdy);
            end
            checks++;
            if (o_busy !== exp_busy) begin
                failures++;
                $display("FAIL tail_busy[%0d]: got %b, required %b", k, o_busy, exp_busy);
            end
            checks++;
            if (o_dout_vld !== exp_dvld) begin
                failures++;
                $display("FAIL tail_dvld[%0d]: got %b, required %b", k, o_dout_vld, exp_dvld);
            end
            checks++;
            if (o_fir_din !== ((exp_rdy && i_din_vld) ? data : 8'h00)) begin
                failures++;
                $display("FAIL tail_fir_din[%0d]: got %h, required %h", k, o_fir_din,
                         (exp_rdy && i_din_vld) ? data : 8'h00);
            end
            checks++;
            if (coeff[0] !== ((k >= 14) ? 8'h80 : 8'h01)) begin
                failures++;
                $display("FAIL tail_coeff0[%0d]: got %h, required %h", k, coeff[0],
                         (k >= 14) ? 8'h80 : 8'h01);
            end
            if (k == 14) begin
                for (int i = 1; i < 7; i++) begin
                    checks++;
                    if (coeff[i] !== exp_coeff[i]) begin
                        failures++;
                        $display("FAIL tail_coeff%0d: got %h, required %h", i, coeff[i],
                                 exp_coeff[i]);
                    end
                end
            end
            if (exp_rdy && i_din_vld) sb_q.push_back(data);
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_coalesced();
        logic exp_busy;
        for (int k = 0; k < 24; k++) begin
            i_commit   = (k == 0) || (k == 2) || (k == 4) || (k == 6);
            i_cfg_vld  = (k == 3);
            i_cfg_addr = 3'd1;
            i_cfg_data = 8'h5A;
            @(negedge clk);
            exp_busy = ((k >= 1) && (k <= 9)) || ((k >= 11) && (k <= 19));
            checks++;
            if (o_busy !== exp_busy) begin
                failures++;
                $display("FAIL coal_busy[%0d]: got %b, required %b", k, o_busy, exp_busy);
            end
            checks++;
            if (o_din_rdy !== !exp_busy) begin
                failures++;
                $display("FAIL coal_rdy[%0d]: got %b, required %b", k, o_din_rdy, !exp_busy);
            end
            checks++;
            if (coeff[1] !== ((k >= 10) ? 8'h5A : 8'h02)) begin
                failures++;
                $display("FAIL coal_coeff1[%0d]: got %h, required %h", k, coeff[1],
                         (k >= 10) ? 8'h5A : 8'h02);
            end
            if (k == 3) begin
                checks++;
                if (o_cfg_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL coal_cfg_rdy_drain: got %b, required 1", o_cfg_rdy);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain();
        logic exp_busy;
        for (int k = 0; k < 21; k++) begin
            rst        = (k == 5);
            i_commit   = (k == 0) || (k == 8);
            i_cfg_vld  = (k == 0);
            i_cfg_addr = 3'd2;
            i_cfg_data = 8'h77;
            @(negedge clk);
            exp_busy = ((k >= 1) && (k <= 5)) || ((k >= 9) && (k <= 17));
            checks++;
            if (o_busy !== exp_busy) begin
                failures++;
                $display("FAIL rstd_busy[%0d]: got %b, required %b", k, o_busy, exp_busy);
            end
            if (k >= 6) begin
                for (int i = 0; i < 7; i++) begin
                    checks++;
                    if (coeff[i] !== 8'h00) begin
                        failures++;
                        $display("FAIL rstd_coeff%0d[%0d]: got %h, required 00", i, k, coeff[i]);
                    end
                end
                checks++;
                if (o_dout_vld !== 1'b0) begin
                    failures++;
                    $display("FAIL rstd_dvld[%0d]: got %b, required 0", k, o_dout_vld);
                end
            end
            if (k == 6) begin
                checks++;
                if (o_din_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL rstd_rdy: got %b, required 1", o_din_rdy);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_config_commit();
        test_latency();
        test_tail();
        test_coalesced();
        test_reset_mid_drain();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d outputs outstanding, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

endmodule
